// File: rtl/mac_result_collector.sv
// -----------------------------------------------------------------------------
// mac_result_collector
//
// Read end of the MAC operand-feed/accumulate protocol. Watches the
// accumulator value (Holder) and the window marker (AccumReset). Each time a
// window closes, the final sum and the number of qualified beats in that
// window are captured into a small FIFO, which is streamed out on a
// valid/ready interface.
//
// Ports:
//   Clk         - system clock, rising edge
//   Reset       - synchronous, active-high reset
//   AccumReset  - window marker; high = accumulator clears at end of cycle
//   In_Valid    - operands presented this cycle are a real beat
//   Holder      - current accumulator value (WIDTH bits)
//   Out_Ready   - downstream accepts the head entry
//   Out_Valid   - FIFO not empty
//   Out_Data    - window sum at the FIFO head (0 when empty)
//   Out_Count   - beat count of the head window (0 when empty)
//   Fifo_Level  - number of stored entries, 0..DEPTH
//   Overflow    - sticky: a window was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module mac_result_collector #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     AccumReset,
    input  logic                     In_Valid,
    input  logic [WIDTH-1:0]         Holder,
    input  logic                     Out_Ready,
    output logic                     Out_Valid,
    output logic [WIDTH-1:0]         Out_Data,
    output logic [CNT_W-1:0]         Out_Count,
    output logic [$clog2(DEPTH):0]   Fifo_Level,
    output logic                     Overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        OPEN
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         beatCnt;
    logic [AW-1:0]            wrPtr;
    logic [AW-1:0]            rdPtr;
    logic [AW:0]              level;
    logic [CNT_W+WIDTH-1:0]   mem [DEPTH];

    logic push;
    logic pop;
    logic full;
    logic writeEn;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        full    = 1'b0;
        writeEn = 1'b0;
        push    = (state == OPEN) && AccumReset;
        full    = (level == (AW+1)'(DEPTH));
        pop     = (level != '0) && Out_Ready;
        // A close into a full FIFO still lands if the head leaves this cycle.
        writeEn = push && (!full || pop) && !Reset;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            beatCnt  <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            level    <= '0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (AccumReset) begin
                        state   <= OPEN;
                        beatCnt <= '0;
                    end
                end
                OPEN: begin
                    // The marker cycle starts the next window, so a beat
                    // qualified alongside it is not counted anywhere.
                    if (AccumReset) begin
                        beatCnt <= '0;
                    end else if (In_Valid && (beatCnt != '1)) begin
                        beatCnt <= beatCnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (writeEn) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end

            if (writeEn && !pop) begin
                level <= level + (AW+1)'(1);
            end else if (!writeEn && pop) begin
                level <= level - (AW+1)'(1);
            end

            if (push && full && !pop) begin
                Overflow <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers and level define
    // which entries are meaningful, and the outputs are masked while empty.
    always_ff @(posedge Clk) begin
        if (writeEn) begin
            mem[wrPtr] <= {beatCnt, Holder};
        end
    end

    assign Out_Valid  = (level != '0);
    assign Out_Data   = Out_Valid ? mem[rdPtr][WIDTH-1:0] : '0;
    assign Out_Count  = Out_Valid ? mem[rdPtr][WIDTH +: CNT_W] : '0;
    assign Fifo_Level = level;

endmodule

// File: tb/tb_mac_result_collector.sv
// -----------------------------------------------------------------------------
// Testbench for mac_result_collector. A queue-based model of the window/FIFO
// behaviour runs alongside the DUT; directed scenarios compare against fixed
// expected values and a randomized run compares against the model each cycle.
// -----------------------------------------------------------------------------
module tb_mac_result_collector;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             AccumReset;
    logic             In_Valid;
    logic [WIDTH-1:0] Holder;
    logic             Out_Ready;
    logic             Out_Valid;
    logic [WIDTH-1:0] Out_Data;
    logic [CNT_W-1:0] Out_Count;
    logic [2:0]       Fifo_Level;
    logic             Overflow;

    always #5 Clk = ~Clk;

    mac_result_collector #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .AccumReset (AccumReset),
        .In_Valid   (In_Valid),
        .Holder     (Holder),
        .Out_Ready  (Out_Ready),
        .Out_Valid  (Out_Valid),
        .Out_Data   (Out_Data),
        .Out_Count  (Out_Count),
        .Fifo_Level (Fifo_Level),
        .Overflow   (Overflow)
    );

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] data;
    } entry_t;

    // Reference model: open-window flag, running beat count, entry queue.
    entry_t q[$];
    bit     mOpen;
    int     mCnt;
    bit     mOvf;

    int nCompared;
    int nMismatched;

    // Drive one cycle of inputs, advance the model across the edge, and
    // return 1 ns after the edge so outputs are sampled away from it.
    task automatic cycle(input bit rst, input bit av, input bit iv,
                         input logic [WIDTH-1:0] h, input bit rdy);
        bit     doPop;
        bit     doPush;
        entry_t e;
        Reset      = rst;
        AccumReset = av;
        In_Valid   = iv;
        Holder     = h;
        Out_Ready  = rdy;
        @(posedge Clk);
        if (rst) begin
            q.delete();
            mOpen = 0;
            mCnt  = 0;
            mOvf  = 0;
        end else begin
            doPop  = (q.size() != 0) && rdy;
            doPush = mOpen && av;
            e.cnt  = CNT_W'(mCnt);
            e.data = h;
            if (doPop) void'(q.pop_front());
            if (doPush) begin
                if (q.size() < DEPTH) q.push_back(e);
                else mOvf = 1;
            end
            if (av) begin
                mOpen = 1;
                mCnt  = 0;
            end else if (mOpen && iv && mCnt < (2**CNT_W - 1)) begin
                mCnt++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, $urandom, 0);
        cycle(1, 1, 1, $urandom, 1);
        nCompared++;
        if (Out_Valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_valid: got %b want 0", Out_Valid);
        end
        nCompared++;
        if (Out_Data !== '0 || Out_Count !== '0) begin
            nMismatched++;
            $display("FAIL reset_head: got data %h count %0d want 0/0", Out_Data, Out_Count);
        end
        nCompared++;
        if (Fifo_Level !== 3'd0 || Overflow !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_level: got level %0d ovf %b want 0/0", Fifo_Level, Overflow);
        end
    endtask

    task automatic test_basic();
        cycle(1, 0, 0, $urandom, 0);
        cycle(0, 1, 0, $urandom, 0);
        nCompared++;
        if (Fifo_Level !== 3'd0) begin
            nMismatched++;
            $display("FAIL basic_first_marker: got level %0d want 0", Fifo_Level);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, $urandom, 0);
        cycle(0, 1, 0, 32'h0000_3F01, 0);
        nCompared++;
        if (Out_Valid !== 1'b1 || Out_Data !== 32'h0000_3F01) begin
            nMismatched++;
            $display("FAIL basic_push: got valid %b data %h want 1/00003f01", Out_Valid, Out_Data);
        end
        nCompared++;
        if (Out_Count !== 8'd3 || Fifo_Level !== 3'd1) begin
            nMismatched++;
            $display("FAIL basic_count: got count %0d level %0d want 3/1", Out_Count, Fifo_Level);
        end
        cycle(0, 0, 0, $urandom, 1);
        nCompared++;
        if (Out_Valid !== 1'b0 || Fifo_Level !== 3'd0) begin
            nMismatched++;
            $display("FAIL basic_pop: got valid %b level %0d want 0/0", Out_Valid, Fifo_Level);
        end
    endtask

    task automatic test_overflow();
        cycle(1, 0, 0, $urandom, 0);
        cycle(0, 1, 0, $urandom, 0);
        for (int i = 1; i <= 5; i++) begin
            cycle(0, 0, 1, $urandom, 0);
            cycle(0, 1, 0, WIDTH'(i), 0);
            if (i == 4) begin
                nCompared++;
                if (Overflow !== 1'b0) begin
                    nMismatched++;
                    $display("FAIL ovf_early: got %b want 0 after 4 closes", Overflow);
                end
            end
        end
        nCompared++;
        if (Fifo_Level !== 3'd4 || Overflow !== 1'b1) begin
            nMismatched++;
            $display("FAIL ovf_full: got level %0d ovf %b want 4/1", Fifo_Level, Overflow);
        end
        for (int i = 1; i <= 4; i++) begin
            nCompared++;
            if (Out_Data !== WIDTH'(i)) begin
                nMismatched++;
                $display("FAIL ovf_drain%0d: got %0d want %0d", i, Out_Data, i);
            end
            cycle(0, 0, 0, $urandom, 1);
        end
        nCompared++;
        if (Out_Valid !== 1'b0 || Overflow !== 1'b1) begin
            nMismatched++;
            $display("FAIL ovf_after: got valid %b ovf %b want 0/1", Out_Valid, Overflow);
        end
    endtask

    task automatic test_full_push_pop();
        cycle(1, 0, 0, $urandom, 0);
        cycle(0, 1, 0, $urandom, 0);
        for (int i = 10; i <= 13; i++) cycle(0, 1, 0, WIDTH'(i), 0);
        cycle(0, 1, 0, 32'd14, 1);
        nCompared++;
        if (Fifo_Level !== 3'd4 || Overflow !== 1'b0) begin
            nMismatched++;
            $display("FAIL fullpp_level: got level %0d ovf %b want 4/0", Fifo_Level, Overflow);
        end
        for (int i = 11; i <= 14; i++) begin
            nCompared++;
            if (Out_Data !== WIDTH'(i)) begin
                nMismatched++;
                $display("FAIL fullpp_drain: got %0d want %0d", Out_Data, i);
            end
            cycle(0, 0, 0, $urandom, 1);
        end
    endtask

    task automatic test_saturation();
        logic [9:0] pattern;
        pattern = 10'b10_1101_0110;
        cycle(1, 0, 0, $urandom, 0);
        cycle(0, 1, 0, $urandom, 0);
        for (int i = 0; i < 300; i++) cycle(0, 0, 1, $urandom, 0);
        cycle(0, 1, 0, 32'hCAFE, 0);
        nCompared++;
        if (Out_Count !== 8'd255 || Out_Data !== 32'hCAFE) begin
            nMismatched++;
            $display("FAIL sat_count: got count %0d data %h want 255/cafe", Out_Count, Out_Data);
        end
        cycle(0, 0, 0, $urandom, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, pattern[i], $urandom, 0);
        cycle(0, 1, 0, 32'hBEEF, 0);
        nCompared++;
        if (Out_Count !== 8'd6) begin
            nMismatched++;
            $display("FAIL gap_count: got %0d want 6", Out_Count);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1, 0, 0, $urandom, 0);
        cycle(0, 1, 0, $urandom, 0);
        cycle(0, 0, 1, $urandom, 0);
        cycle(0, 0, 1, $urandom, 0);
        cycle(0, 1, 1, 32'hAAAA, 0);
        cycle(0, 1, 1, 32'hBBBB, 0);
        nCompared++;
        if (Fifo_Level !== 3'd2 || Out_Count !== 8'd2 || Out_Data !== 32'hAAAA) begin
            nMismatched++;
            $display("FAIL b2b_first: got level %0d count %0d data %h want 2/2/aaaa",
                     Fifo_Level, Out_Count, Out_Data);
        end
        cycle(0, 0, 0, $urandom, 1);
        nCompared++;
        if (Out_Count !== 8'd0 || Out_Data !== 32'hBBBB) begin
            nMismatched++;
            $display("FAIL b2b_second: got count %0d data %h want 0/bbbb", Out_Count, Out_Data);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, $urandom, 0);
        cycle(0, 1, 0, $urandom, 0);
        cycle(0, 1, 0, 32'd1, 0);
        cycle(0, 1, 0, 32'd2, 0);
        cycle(0, 0, 1, $urandom, 0);
        cycle(1, 1, 1, $urandom, 0);
        nCompared++;
        if (Out_Valid !== 1'b0 || Fifo_Level !== 3'd0 || Overflow !== 1'b0) begin
            nMismatched++;
            $display("FAIL rstmid_clear: got valid %b level %0d ovf %b want 0/0/0",
                     Out_Valid, Fifo_Level, Overflow);
        end
        cycle(0, 1, 0, $urandom, 0);
        nCompared++;
        if (Fifo_Level !== 3'd0) begin
            nMismatched++;
            $display("FAIL rstmid_open: got level %0d want 0", Fifo_Level);
        end
        cycle(0, 1, 0, 32'd7, 0);
        nCompared++;
        if (Fifo_Level !== 3'd1 || Out_Count !== 8'd0 || Out_Data !== 32'd7) begin
            nMismatched++;
            $display("FAIL rstmid_empty_win: got level %0d count %0d data %0d want 1/0/7",
                     Fifo_Level, Out_Count, Out_Data);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] expData;
        logic [CNT_W-1:0] expCount;
        bit               rdy;
        cycle(1, 0, 0, $urandom, 0);
        for (int i = 0; i < 3000; i++) begin
            if (((i / 400) % 2) == 0) rdy = ($urandom_range(0, 3) == 0);
            else                      rdy = ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0, $urandom, rdy);
            expData  = (q.size() != 0) ? q[0].data : '0;
            expCount = (q.size() != 0) ? q[0].cnt  : '0;
            nCompared++;
            if (Out_Valid !== (q.size() != 0) || Fifo_Level !== 3'(q.size())) begin
                nMismatched++;
                $display("FAIL rand_level@%0d: got valid %b level %0d want %b/%0d",
                         i, Out_Valid, Fifo_Level, q.size() != 0, q.size());
            end
            nCompared++;
            if (Out_Data !== expData || Out_Count !== expCount) begin
                nMismatched++;
                $display("FAIL rand_head@%0d: got %h/%0d want %h/%0d",
                         i, Out_Data, Out_Count, expData, expCount);
            end
            nCompared++;
            if (Overflow !== mOvf) begin
                nMismatched++;
                $display("FAIL rand_ovf@%0d: got %b want %b", i, Overflow, mOvf);
            end
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        mOpen = 0;
        mCnt  = 0;
        mOvf  = 0;
        Reset      = 1'b1;
        AccumReset = 1'b0;
        In_Valid   = 1'b0;
        Holder     = '0;
        Out_Ready  = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
- Result-side consumer of the multiply-accumulate hold block.
- Watches the accumulator output (Holder) and the window marker (AccumReset).
- At each window close, captures the final sum and its beat count into a small FIFO, then streams the entries out on a valid/ready interface.
- Sits between the MAC datapath and downstream convolution output logic; it is the read end of the operand-feed/accumulate protocol.

Parameters:
- WIDTH, 32, width of Holder and Out_Data.
- CNT_W, 8, width of the per-window beat counter and Out_Count.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- AccumReset  input  1  window marker from the MAC controller; high means the accumulator clears at the end of this cycle.
- In_Valid  input  1  high when the x/y operands presented this cycle are a real beat.
- Holder  input  WIDTH  current accumulator value from the MAC.
- Out_Ready  input  1  downstream accepts the head entry.
- Out_Valid  output  1  FIFO not empty.
- Out_Data  output  WIDTH  captured window sum at the FIFO head.
- Out_Count  output  CNT_W  beat count of the head window.
- Fifo_Level  output  log2(DEPTH)+1  number of stored entries.
- Overflow  output  1  sticky: a window was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, takes priority over all other events):
  - State goes to IDLE; beat counter, FIFO pointers and Fifo_Level go to 0.
  - Out_Valid=0, Out_Data=0, Out_Count=0, Overflow=0.
  - Reset mid-window discards the open window; no push occurs.
- IDLE:
  - Ignores Holder and In_Valid.
  - AccumReset=1 moves to OPEN with beat counter=0.
  - The first marker only opens a window and pushes nothing.
- OPEN:
  - Each cycle with AccumReset=0 and In_Valid=1 increments the beat counter.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
- Window close (AccumReset=1 while in OPEN):
  - Push {beat counter, Holder}, using Holder as sampled in that same cycle, i.e. the final sum before the MAC clears.
  - The beat counter goes to 0 on the same edge and the state stays OPEN (back-to-back windows).
  - Beats qualified in the marker cycle are not counted; the marker cycle belongs to the new window.
- Empty windows: a close with beat counter=0 still pushes, with Out_Count=0 and Out_Data=Holder.
- FIFO:
  - Registered storage. A push becomes visible at the head one cycle later (Out_Valid rises on the edge after the close cycle).
  - Out_Data and Out_Count show the head entry combinationally from storage. They hold stable while Out_Valid=1 and Out_Ready=0.
  - Pop occurs when Out_Valid=1 and Out_Ready=1.
- Simultaneous push and pop:
  - Allowed at any level, including full. Level is unchanged.
  - At level 1, the popped entry leaves and the new entry becomes the head on the next cycle, so Out_Valid stays 1.
- Push when full with no pop:
  - The entry is dropped and Overflow is set to 1. Overflow stays 1 until Reset.
  - Stored entries are unaffected.
- Pop when empty: impossible by definition, since Out_Valid=0; Out_Ready is ignored.
- Pointers wrap modulo DEPTH. Fifo_Level ranges 0..DEPTH.
- Arithmetic: Holder is stored unmodified; no sign or width change.

Test Plan:
- Reset, then AccumReset pulse, then 3 beats with In_Valid=1, then AccumReset with Holder=32'h0000_3F01 -> one cycle later Out_Valid=1, Out_Data=32'h0000_3F01, Out_Count=3, Fifo_Level=1; Out_Ready=1 pops and Out_Valid falls.
- Out_Ready held 0, five windows closed (DEPTH=4) with Holder=1,2,3,4,5 -> Fifo_Level=4, Overflow=1 after the fifth close; draining yields 1,2,3,4 in order, and 5 is lost.
- FIFO full, window close in the same cycle as Out_Ready=1 -> no overflow, level stays 4, new entry appears last in drain order.
- 300 beats in one window with CNT_W=8 -> Out_Count=255; In_Valid=0 gaps are not counted (10 cycles with 6 valid gives Out_Count=6).
- Back-to-back markers (AccumReset high 2 consecutive cycles in OPEN) -> two pushes, the second with Out_Count=0.
- Reset asserted with 2 entries stored and a window open -> next cycle Out_Valid=0, Fifo_Level=0, Overflow=0; the following AccumReset opens a window without pushing.
